// File: rtl/window_streamer_if.sv
// Handshake bundle for window_streamer: the raster pixel input side and the WIN x WIN window output side.
interface window_streamer_if #(
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 480,
  parameter int WIN        = 6,
  parameter int PIXEL_W    = 8
);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);

  logic [PIXEL_W-1:0]         pixel;
  logic                       pixel_valid;
  logic                       pixel_sof;
  logic                       pixel_ready;
  logic [WIN*WIN*PIXEL_W-1:0] window;
  logic                       window_valid;
  logic                       window_ready;
  logic [ROW_W-1:0]           window_row;
  logic [COL_W-1:0]           window_col;
  logic                       window_eof;

  modport master (
    output pixel, pixel_valid, pixel_sof, window_ready,
    input  pixel_ready, window, window_valid, window_row, window_col, window_eof
  );

  modport slave (
    input  pixel, pixel_valid, pixel_sof, window_ready,
    output pixel_ready, window, window_valid, window_row, window_col, window_eof
  );
endinterface

// File: rtl/window_streamer.sv
// Sliding WIN x WIN window generator over a raster pixel stream using WIN-1 rotating line buffers.
// Optional macro WINDOW_STATS_EN adds a 16-bit completed-frame counter output frame_count.
module window_streamer #(
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 480,
  parameter int WIN        = 6,
  parameter int PIXEL_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  window_streamer_if.slave  strm
`ifdef WINDOW_STATS_EN
  ,
  output logic [15:0]       frame_count
`endif
);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int NBUF   = WIN - 1;
  localparam int HEAD_W = (NBUF > 1) ? $clog2(NBUF) : 1;

  logic [COL_W-1:0]   colCnt;
  logic [ROW_W-1:0]   rowCnt;
  logic [HEAD_W-1:0]  headPtr;
  logic [PIXEL_W-1:0] lineBuf [NBUF][IMG_WIDTH];

  logic [PIXEL_W-1:0] winShift_p1 [WIN][WIN];
  logic               vld_p1;
  logic               eof_p1;
  logic [ROW_W-1:0]   winRow_p1;
  logic [COL_W-1:0]   winCol_p1;

  logic               accept;
  logic               produce;
  logic               colWrap;
  logic               lastPix;
  logic [COL_W-1:0]   curCol;
  logic [ROW_W-1:0]   curRow;
  logic [PIXEL_W-1:0] newColumn [WIN];

  // Physical buffer holding the k-th oldest stored row.
  function automatic logic [HEAD_W-1:0] bufIdx(input logic [HEAD_W-1:0] head, input int k);
    int s;
    s = int'(head) + k;
    if (s >= NBUF) s = s - NBUF;
    return HEAD_W'(s);
  endfunction

  assign strm.pixel_ready = !vld_p1 || strm.window_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of where the counters stand.
  always_comb begin
    accept  = strm.pixel_valid && strm.pixel_ready;
    curCol  = strm.pixel_sof ? '0 : colCnt;
    curRow  = strm.pixel_sof ? '0 : rowCnt;
    colWrap = (curCol == COL_W'(IMG_WIDTH - 1));
    lastPix = colWrap && (curRow == ROW_W'(IMG_HEIGHT - 1));
    produce = (curRow >= ROW_W'(WIN - 1)) && (curCol >= COL_W'(WIN - 1));
    for (int k = 0; k < NBUF; k++) begin
      newColumn[k] = lineBuf[bufIdx(headPtr, k)][curCol];
    end
    newColumn[WIN-1] = strm.pixel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colCnt  <= '0;
      rowCnt  <= '0;
      headPtr <= '0;
    end else if (accept) begin
      if (colWrap) begin
        colCnt  <= '0;
        rowCnt  <= lastPix ? '0 : curRow + ROW_W'(1);
        headPtr <= (headPtr == HEAD_W'(NBUF - 1)) ? '0 : headPtr + HEAD_W'(1);
      end else begin
        colCnt  <= curCol + COL_W'(1);
        rowCnt  <= curRow;
      end
    end
  end

  // Incoming pixel replaces the oldest row at this column; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) lineBuf[headPtr][curCol] <= strm.pixel;
  end

  // ---- stage p1: window shift register and output qualifiers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      eof_p1    <= 1'b0;
      winRow_p1 <= '0;
      winCol_p1 <= '0;
      for (int k = 0; k < WIN; k++) begin
        for (int q = 0; q < WIN; q++) winShift_p1[k][q] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < WIN; k++) begin
        for (int q = 0; q < WIN - 1; q++) winShift_p1[k][q] <= winShift_p1[k][q+1];
        winShift_p1[k][WIN-1] <= newColumn[k];
      end
      vld_p1 <= produce;
      eof_p1 <= lastPix;
      if (produce) begin
        winRow_p1 <= curRow - ROW_W'(WIN - 1);
        winCol_p1 <= curCol - COL_W'(WIN - 1);
      end
    end else if (strm.window_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    strm.window = '0;
    for (int k = 0; k < WIN; k++) begin
      for (int q = 0; q < WIN; q++) strm.window[(k*WIN+q)*PIXEL_W +: PIXEL_W] = winShift_p1[k][q];
    end
  end

  assign strm.window_valid = vld_p1;
  assign strm.window_eof   = eof_p1;
  assign strm.window_row   = winRow_p1;
  assign strm.window_col   = winCol_p1;

`ifdef WINDOW_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 frame_count <= '0;
    else if (accept && lastPix) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule

// File: doc/window_streamer.md
# window_streamer

Parametrised sliding-window generator for the Harris corner pipeline front end. Accepts a raster-order pixel stream under valid/ready handshake, buffers WIN-1 image rows in rotating line buffers, and emits one WIN×WIN window per input pixel whose window lies fully inside the frame. It sits between the camera/frame source and the gradient/Harris response stages. Over the previous fixed 6×6, 480-wide window generator it adds:

- generic geometry;
- backpressure;
- frame sync;
- window coordinates;
- end-of-frame marking.

## Interface
- IMG_WIDTH, 480, pixels per row (≥ WIN)
- IMG_HEIGHT, 480, rows per frame (≥ WIN)
- WIN, 6, window edge length (2..8)
- PIXEL_W, 8, bits per pixel
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pixel  in  PIXEL_W  input pixel
- pixel_valid  in  1  pixel qualifier
- pixel_sof  in  1  pixel is frame (0,0); sampled only on accept
- pixel_ready  out  1  block can accept a pixel
- window  out  WIN*WIN*PIXEL_W  flattened window; element (k,q) at bits [(k*WIN+q+1)*PIXEL_W-1 -: PIXEL_W]; k=0 top (oldest) row, q=0 leftmost column
- window_valid  out  1  window qualifier
- window_ready  in  1  downstream accepts window
- window_row  out  $clog2(IMG_HEIGHT)  top-left row of window
- window_col  out  $clog2(IMG_WIDTH)  top-left column of window
- window_eof  out  1  window is the last of the frame
- frame_count  out  16  only with WINDOW_STATS_EN

## Operation
- **Accept:** a pixel is accepted when pixel_valid && pixel_ready. pixel_ready = !window_valid || window_ready (single output register, combinational ready).
- **Position counters:** col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 track the position of the next pixel.
  - On accept, col increments; at IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- **Line buffers:** WIN-1 buffers of IMG_WIDTH entries, used as a circular set indexed by a rotating head pointer that advances at each row wrap.
  - On accept at column c, each buffer is read at c, ordered oldest to newest.
  - The window shift register shifts left one column. The new right column is [buffer reads oldest..newest, incoming pixel], top to bottom.
  - The incoming pixel overwrites the oldest buffer at c.
- **Window output:** a window is produced for the accepted pixel at (r,c) iff r ≥ WIN-1 and c ≥ WIN-1.
  - window_row = r-(WIN-1), window_col = c-(WIN-1).
  - window_eof = (r,c) == (IMG_HEIGHT-1, IMG_WIDTH-1).
- **Windows per frame:** (IMG_HEIGHT-WIN+1)*(IMG_WIDTH-WIN+1).
- **Idle accepts:** an accept that produces no window clears window_valid, if the current window is consumed or none is held.
- **pixel_sof:**
  - Accepted with sof=1 while counters ≠ (0,0): the pixel is treated as (0,0), counters are forced accordingly, and no window is produced until row WIN-1, col WIN-1 of the new frame. Line buffer contents are not cleared.
  - sof=0 on a pixel at (0,0) is legal; the counters govern.
- **Stale data:** windows never mix frames or rows, because gating uses counters only and stale buffer contents are never emitted.

## Timing
- **Latency:** window, window_row, window_col and window_eof are registered. They become valid the cycle after the accept edge that produces them.
- **Throughput:** one pixel and one window per cycle when window_ready is held high.
- **Hold stability:** while window_valid && !window_ready, all window outputs hold stable and pixel_ready = 0.
- **Reset (asynchronous assert, synchronous release):**
  - window_valid = 0, window_eof = 0, window = 0, window_row = 0, window_col = 0, frame_count = 0.
  - Counters = (0,0), head pointer = 0.
  - pixel_ready = 1 (follows from window_valid = 0).
  - Line buffer contents are don't-care.
- **Reset mid-frame:** the partial frame is discarded. The next accepted pixel is (0,0).

## Configuration
- **WINDOW_STATS_EN defined:** frame_count increments (wrapping at 16 bits) on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- **WINDOW_STATS_EN undefined:** the frame_count port and its register are absent. All other behaviour is identical.

## Test plan
All tests use IMG_WIDTH=8, IMG_HEIGHT=6, WIN=3, PIXEL_W=8, and pixel value = r*8+c.
- **Full frame, window_ready=1, continuous valid:**
  - First window_valid comes one cycle after pixel 18 is accepted; window rows = 0,1,2 / 8,9,10 / 16,17,18; row=0, col=0.
  - Exactly 24 windows.
  - Last window has row=3, col=5, eof=1, bottom-right element = 47.
- **Backpressure:** window_ready=0 for 5 cycles during a window.
  - pixel_ready=0 and window is unchanged for those cycles.
  - No pixel is lost; window count is 24 and the values match the first test.
- **Back-to-back frames (values +100 in frame 2):**
  - No window appears between frame 2 pixels 0..17.
  - Frame 2 first window = 100,101,102 / 108,109,110 / 116,117,118.
- **SOF resync:** pixel_sof=1 on stream index 20.
  - Counters restart; the next window appears one cycle after the 19th pixel counted from index 20, with row=0, col=0.
- **Async reset mid-frame:** assert reset between clock edges at pixel 30.
  - Outputs go to 0 immediately.
  - After release, a fresh frame produces its first window after pixel 18.
- **WINDOW_STATS_EN build:** after 3 full frames, frame_count=3; after reset, frame_count=0.
